pipe_hazard_ctrl: RTL
=====================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have parameter RAW, default 5: register-address width.
REQ-002 SHALL have parameter NSTAGE, default 3, legal 2..4: number of tracked stages after ID (stage 1 = EXE, stage 2 = MEM, ...).
REQ-003 SHALL have parameter MD_CYCLES, default 8, legal 2..32: multi-cycle mul/div occupancy in cycles.
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  reset, asynchronous, active-low.
REQ-006 cmu_stall  in  1  cache stall; freezes everything.
REQ-007 branch_id  in  1  taken branch resolved in ID.
REQ-008 rs1use_id, rs2use_id  in  1 each  ID instruction reads rs1 / rs2.
REQ-009 rs1_id, rs2_id, rd_id  in  RAW each  ID register addresses.
REQ-010 optype_id  in  3  0 NONE, 1 ALU, 2 LOAD, 3 STORE, 4 MULDIV; 5..7 treated as NONE.
REQ-011 pc_en_if, fd_en, fd_stall, fd_flush, de_en, de_flush, em_en, mw_en  out  1 each  stage enables, stalls and flushes.
REQ-012 fwd_a, fwd_b  out  3 each  0 = register file, k = forward from stage k (1..NSTAGE).
REQ-013 fwd_ls  out  1  store-data forward from MEM load (stage 2) to store in EXE.
REQ-014 md_busy  out  1  mul/div unit occupied.

Function
REQ-015 SHALL keep internal per-stage rd and optype registers for stages 1..NSTAGE; each cycle with cmu_stall=0, stage k+1 takes stage k and stage 1 takes ID, or NONE when de_flush=1.
REQ-016 The ID operand is a match against stage k when: the corresponding use bit is set, the address equals stage-k rd, rd is nonzero, and stage-k optype is ALU or LOAD.
REQ-017 fwd_a/fwd_b SHALL select the lowest-numbered matching stage; 0 when no stage matches. A LOAD match at stage 1 never forwards.
REQ-018 load_stall SHALL be asserted when either operand matches a LOAD in stage 1, except the rs2 operand of a STORE when HAZARD_LS_FWD_EN is defined.
REQ-019 An MD counter SHALL load MD_CYCLES when a MULDIV leaves ID unstalled. It SHALL decrement each cycle while nonzero and cmu_stall=0; md_busy = counter != 0.
REQ-020 md_stall SHALL be asserted when md_busy is set and the ID instruction is one of: a MULDIV; an instruction using rs1 or rs2 equal to the latched MD rd (nonzero); an instruction writing the latched MD rd (WAW).
REQ-021 With stall = load_stall | md_stall: pc_en_if = ~stall & ~cmu_stall; fd_stall = stall; de_flush = stall & ~cmu_stall; fd_en = de_en = em_en = mw_en = ~cmu_stall.
REQ-022 fd_flush = branch_id & ~stall: a stall takes priority and the branch re-resolves next cycle.
REQ-023 fwd_ls = 1 when stage-1 optype is STORE, stage-2 optype is LOAD, and stage-1 rs2 (tracked) equals stage-2 rd (nonzero).
REQ-024 All outputs are combinational from the current state and inputs, with zero-cycle latency; state updates on the clk rising edge only.

Reset
REQ-025 rst_n low SHALL immediately set all stage optypes to NONE, rd to 0, the MD counter to 0 and the latched MD rd to 0, including mid-MULDIV.
REQ-026 During reset outputs SHALL be: fwd_a = fwd_b = 0, fwd_ls = 0, md_busy = 0, stall flushes 0, and enables = ~cmu_stall.

Configuration
REQ-027 Macro HAZARD_LS_FWD_EN defined: a STORE whose rs2 matches a LOAD in stage 1 does not stall, and fwd_ls is produced per REQ-023.
REQ-028 Macro absent: that case stalls one cycle per REQ-018, and fwd_ls is tied to 0.

Verification
REQ-029 ALU x5 in EXE, next ID uses rs1=x5 -> fwd_a=1, no stall. One cycle later -> fwd_a=2.
REQ-030 LOAD x6 followed by ADD rs2=x6 -> one cycle with fd_stall=1, de_flush=1, pc_en_if=0, then fwd_b=2.
REQ-031 LOAD x7 followed by STORE rs2=x7 -> with macro: no stall, fwd_ls=1 next cycle. Without macro: one stall cycle, fwd_ls=0.
REQ-032 MULDIV x8 (MD_CYCLES=8) followed by an x8 consumer -> md_busy high for 8 cycles; consumer stalls until md_busy=0. rst_n pulsed mid-count -> md_busy=0 immediately.
REQ-033 branch_id=1 concurrent with load_stall -> fd_flush=0 that cycle; the next cycle branch_id=1 with no stall -> fd_flush=1.
REQ-034 cmu_stall=1 for 3 cycles during a load-use -> all enables 0, de_flush=0, tracking unchanged; resumes with the identical stall sequence afterwards.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for an in-order pipeline: forwarding selects, load-use / mul-div stalls, flushes.
// Latency: all outputs combinational (zero cycle); stage tracking and the mul/div counter update on clk.
// Backpressure: cmu_stall freezes all tracking and drops every enable; a hazard stall holds IF/ID and bubbles EXE.
// Optional feature: HAZARD_LS_FWD_EN enables load-to-store data forwarding instead of a load-use stall.
module pipe_hazard_ctrl #(
    parameter int RAW       = 5,
    parameter int NSTAGE    = 3,
    parameter int MD_CYCLES = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           cmu_stall,
    input  logic           branch_id,
    input  logic           rs1use_id,
    input  logic           rs2use_id,
    input  logic [RAW-1:0] rs1_id,
    input  logic [RAW-1:0] rs2_id,
    input  logic [RAW-1:0] rd_id,
    input  logic [2:0]     optype_id,
    output logic           pc_en_if,
    output logic           fd_en,
    output logic           fd_stall,
    output logic           fd_flush,
    output logic           de_en,
    output logic           de_flush,
    output logic           em_en,
    output logic           mw_en,
    output logic [2:0]     fwd_a,
    output logic [2:0]     fwd_b,
    output logic           fwd_ls,
    output logic           md_busy
);

    localparam int MDW = $clog2(MD_CYCLES + 1);

    typedef enum logic [2:0] {
        OP_NONE   = 3'd0,
        OP_ALU    = 3'd1,
        OP_LOAD   = 3'd2,
        OP_STORE  = 3'd3,
        OP_MULDIV = 3'd4
    } op_t;

    typedef struct packed {
        op_t            op;
        logic [RAW-1:0] rd;
    } stage_t;

    op_t            op_id;
    stage_t         stg [1:NSTAGE];
    logic [NSTAGE:1] match_a;
    logic [NSTAGE:1] match_b;
    logic           s1_load;
    logic           ls_exempt;
    logic           load_stall;
    logic           md_stall;
    logic           stall;
    logic           md_start;
    logic           id_writes;
    logic [MDW-1:0] md_cnt;
    logic [RAW-1:0] md_rd;

    // Undefined optype encodings behave as NONE everywhere downstream.
    always_comb begin
        case (optype_id)
            3'd1:    op_id = OP_ALU;
            3'd2:    op_id = OP_LOAD;
            3'd3:    op_id = OP_STORE;
            3'd4:    op_id = OP_MULDIV;
            default: op_id = OP_NONE;
        endcase
    end

    function automatic logic fwdable(input stage_t s);
        return (s.rd != '0) && ((s.op == OP_ALU) || (s.op == OP_LOAD));
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 1; k <= NSTAGE; k++) begin
                stg[k] <= '{op: OP_NONE, rd: '0};
            end
        end else if (!cmu_stall) begin
            for (int k = NSTAGE; k >= 2; k--) begin
                stg[k] <= stg[k-1];
            end
            if (de_flush) begin
                stg[1] <= '{op: OP_NONE, rd: '0};
            end else begin
                stg[1] <= '{op: op_id, rd: rd_id};
            end
        end
    end

    always_comb begin
        match_a = '0;
        match_b = '0;
        for (int k = 1; k <= NSTAGE; k++) begin
            match_a[k] = rs1use_id && (rs1_id == stg[k].rd) && fwdable(stg[k]);
            match_b[k] = rs2use_id && (rs2_id == stg[k].rd) && fwdable(stg[k]);
        end
    end

    // Scan oldest-to-youngest so the youngest producer wins; a load still in EXE has no data yet.
    always_comb begin
        fwd_a = '0;
        fwd_b = '0;
        for (int k = NSTAGE; k >= 1; k--) begin
            if (match_a[k]) fwd_a = 3'(k);
            if (match_b[k]) fwd_b = 3'(k);
        end
        if (match_a[1] && s1_load) fwd_a = '0;
        if (match_b[1] && s1_load) fwd_b = '0;
    end

    assign s1_load = (stg[1].op == OP_LOAD);

`ifdef HAZARD_LS_FWD_EN
    logic [RAW-1:0] s1_rs2;

    // Store data can be picked up from the load's MEM result one cycle later, so only rs2 is exempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_rs2 <= '0;
        end else if (!cmu_stall) begin
            s1_rs2 <= de_flush ? '0 : rs2_id;
        end
    end

    assign ls_exempt = (op_id == OP_STORE);
    assign fwd_ls    = (stg[1].op == OP_STORE) && (stg[2].op == OP_LOAD) &&
                       (s1_rs2 == stg[2].rd) && (stg[2].rd != '0);
`else
    assign ls_exempt = 1'b0;
    assign fwd_ls    = 1'b0;
`endif

    assign load_stall = s1_load && (match_a[1] || (match_b[1] && !ls_exempt));

    assign id_writes = (op_id == OP_ALU) || (op_id == OP_LOAD) || (op_id == OP_MULDIV);

    assign md_busy  = (md_cnt != '0);
    assign md_stall = md_busy && (
                          (op_id == OP_MULDIV) ||
                          (md_rd != '0 && rs1use_id && rs1_id == md_rd) ||
                          (md_rd != '0 && rs2use_id && rs2_id == md_rd) ||
                          (md_rd != '0 && id_writes && rd_id == md_rd));

    assign stall    = load_stall || md_stall;
    assign md_start = (op_id == OP_MULDIV) && !stall && !cmu_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            md_cnt <= '0;
            md_rd  <= '0;
        end else if (md_start) begin
            md_cnt <= MDW'(MD_CYCLES);
            md_rd  <= rd_id;
        end else if (md_busy && !cmu_stall) begin
            md_cnt <= md_cnt - 1'b1;
        end
    end

    assign pc_en_if = !stall && !cmu_stall;
    assign fd_stall = stall;
    assign de_flush = stall && !cmu_stall;
    assign fd_flush = branch_id && !stall;
    assign fd_en    = !cmu_stall;
    assign de_en    = !cmu_stall;
    assign em_en    = !cmu_stall;
    assign mw_en    = !cmu_stall;

endmodule
